axis_frame_check: RTL
=====================

AXIS_FRAME_CHECK -- requirements
Module: axis_frame_check

Interface
REQ-001 SHALL have parameter ACTIVE_W, default 1920, active pixels per line.
REQ-002 SHALL have parameter ACTIVE_H, default 1080, active lines per frame.
REQ-003 SHALL have parameter TIMEOUT, default 4096, idle cycles mid-frame before abort.
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_tdata  input  24  pixel data, 8:8:8.
REQ-007 SHALL have port s_tvalid  input  1  beat valid.
REQ-008 SHALL have port s_tready  output  1  sink ready.
REQ-009 SHALL have port s_tuser  input  1  start of frame, first beat only.
REQ-010 SHALL have port s_tlast  input  1  end of line, last beat of each line.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when a frame is closed.
REQ-012 SHALL have port frame_ok  output  1  latched: last closed frame error-free.
REQ-013 SHALL have port frame_err  output  4  latched error bits of last closed frame.
REQ-014 SHALL have port frame_lines  output  16  latched line count of last closed frame.
REQ-015 SHALL have port frame_sum  output  32  latched pixel checksum of last closed frame.
REQ-016 SHALL have port frame_cnt  output  16  count of frames closed with frame_ok=1.

Function
REQ-017 SHALL hold s_tready=0 during reset and the cycle after; 1 otherwise; beat = s_tvalid & s_tready.
REQ-018 SHALL implement states IDLE (await SOF) and ACTIVE (in frame); reset state IDLE.
REQ-019 In IDLE, beat with s_tuser=0 SHALL be discarded and set pending err bit0 (pre-SOF data).
REQ-020 In IDLE, beat with s_tuser=1 SHALL enter ACTIVE, start pix=1, line=0, sum=s_tdata zero-extended, pending bits[3:1] cleared.
REQ-021 In ACTIVE, each beat SHALL increment pix and add s_tdata to sum modulo 2^32.
REQ-022 Beat with s_tlast=1 SHALL set err bit1 if pix count including that beat != ACTIVE_W, then increment line and reset pix to 0.
REQ-023 Beat ACTIVE_W of a line without s_tlast SHALL set err bit1 once; counting continues until s_tlast.
REQ-024 When line reaches ACTIVE_H after a tlast beat, SHALL close the frame and return to IDLE.
REQ-025 Beat with s_tuser=1 in ACTIVE SHALL set err bit2, close current frame (excluding that beat), and open a new frame with that beat as first pixel.
REQ-026 In ACTIVE, TIMEOUT consecutive cycles without a beat SHALL set err bit3, close frame, return to IDLE.
REQ-027 Closing a frame SHALL, one cycle after the closing beat/timeout, pulse frame_done and latch frame_err=pending bits, frame_ok=(pending==0), frame_lines=line, frame_sum=sum.
REQ-028 Pending bit0 SHALL be reported in the next closed frame then cleared.
REQ-029 frame_cnt SHALL increment on frame_done when frame_ok=1, wrapping 0xFFFF->0.
REQ-030 s_tuser and s_tlast on the same beat SHALL apply REQ-020/025 first, then REQ-022.

Reset
REQ-031 Reset SHALL force: state IDLE, s_tready=0, frame_done=0, frame_ok=0, frame_err=0, frame_lines=0, frame_sum=0, frame_cnt=0, internal counters 0.
REQ-032 Reset mid-frame SHALL abandon the frame without a frame_done pulse.

Structure
REQ-033 Error bit indices (0 pre-SOF, 1 line length, 2 early SOF, 3 timeout) and state encodings SHALL be constants in a shared video package.
REQ-034 Block SHALL be a single module; no sub-module required.

Verification (ACTIVE_W=8, ACTIVE_H=4, TIMEOUT=16 unless stated)
REQ-035 Clean frame, tdata ramp 0..31, tuser beat 0, tlast every 8th -> frame_done one cycle after beat 31, frame_ok=1, frame_err=0, frame_lines=4, frame_sum=496, frame_cnt=1.
REQ-036 Line 2 with tlast on 7th beat -> frame_ok=0, frame_err=4'b0010, frame_lines=4, frame_cnt unchanged.
REQ-037 Three beats without tuser, then clean frame -> frame_err=4'b0001; following clean frame -> frame_err=0.
REQ-038 tuser reasserted at line 2 pixel 3 -> frame_done with frame_err=4'b0100, frame_lines=2; new frame completes clean with frame_ok=1.
REQ-039 Stop tvalid after 10 beats for 16 cycles -> frame_done, frame_err=4'b1000, state IDLE.
REQ-040 Defaults 1920x1080, generator-style stream (tvalid gaps between lines) -> frame_lines=1080, frame_ok=1; reset asserted mid-frame -> no frame_done, outputs 0.

Source files
------------

// File: rtl/axis_frame_check_pkg.sv
// Shared video constants for the AXI4-Stream frame checker:
// error bit positions, FSM state encodings and the pixel-to-checksum helper.
`timescale 1ns/1ps
package axis_frame_check_pkg;

    localparam int ERR_PRE_SOF   = 0;
    localparam int ERR_LINE_LEN  = 1;
    localparam int ERR_EARLY_SOF = 2;
    localparam int ERR_TIMEOUT   = 3;
    localparam int ERR_W         = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    typedef logic [ERR_W-1:0] err_t;

    function automatic logic [31:0] pixelWord(input logic [23:0] pix);
        return {8'h00, pix};
    endfunction

endpackage

// File: rtl/axis_frame_check.sv
// Checks incoming AXI4-Stream video frames for geometry, SOF placement and stalls,
// and reports per-frame line count, pixel checksum and error bits.
`timescale 1ns/1ps
module axis_frame_check
    import axis_frame_check_pkg::*;
#(
    parameter int ACTIVE_W = 1920,
    parameter int ACTIVE_H = 1080,
    parameter int TIMEOUT  = 4096
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [23:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tuser,
    input  logic        s_tlast,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [3:0]  frame_err,
    output logic [15:0] frame_lines,
    output logic [31:0] frame_sum,
    output logic [15:0] frame_cnt
);

    localparam int          TW  = $clog2(TIMEOUT + 1);
    localparam logic [15:0] W16 = 16'(ACTIVE_W);
    localparam logic [15:0] H16 = 16'(ACTIVE_H);
    localparam logic [TW-1:0] TO = TW'(TIMEOUT);

    logic          readyQ;
    logic [0:0]    stateQ, stateD;
    logic [15:0]   pixQ, pixD;
    logic [15:0]   lineQ, lineD;
    logic [31:0]   sumQ, sumD;
    err_t          pendQ, pendD;
    logic [TW-1:0] idleQ, idleD;

    logic          doneQ, okQ;
    err_t          errQ;
    logic [15:0]   linesQ, cntQ;
    logic [31:0]   sumOutQ;

    logic          beat, openNew, closeEn;
    err_t          closeErr;
    logic [15:0]   closeLines;
    logic [31:0]   closeSum;

    assign s_tready = readyQ & ~reset;
    assign beat     = s_tvalid & s_tready;

    // An SOF beat (in IDLE, or early in ACTIVE) is handled before its tlast,
    // so a single beat may both open a frame and terminate its first line.
    always_comb begin
        stateD     = stateQ;
        pixD       = pixQ;
        lineD      = lineQ;
        sumD       = sumQ;
        pendD      = pendQ;
        idleD      = '0;
        openNew    = 1'b0;
        closeEn    = 1'b0;
        closeErr   = pendQ;
        closeLines = lineQ;
        closeSum   = sumQ;

        if (stateQ == ST_IDLE) begin
            if (beat) begin
                if (s_tuser) begin
                    openNew = 1'b1;
                end else begin
                    pendD[ERR_PRE_SOF] = 1'b1;
                end
            end
        end else if (beat) begin
            if (s_tuser) begin
                closeEn                 = 1'b1;
                closeErr[ERR_EARLY_SOF] = 1'b1;
                pendD                   = '0;
                openNew                 = 1'b1;
            end else begin
                pixD = pixQ + 16'd1;
                sumD = sumQ + pixelWord(s_tdata);
            end
        end else begin
            idleD = idleQ + TW'(1);
            if (idleD == TO) begin
                closeEn               = 1'b1;
                closeErr[ERR_TIMEOUT] = 1'b1;
                stateD                = ST_IDLE;
                pendD                 = '0;
                idleD                 = '0;
            end
        end

        if (openNew) begin
            stateD                             = ST_ACTIVE;
            pixD                               = 16'd1;
            lineD                              = 16'd0;
            sumD                               = pixelWord(s_tdata);
            pendD[ERR_TIMEOUT:ERR_LINE_LEN]    = '0;
        end

        if (beat && (stateD == ST_ACTIVE) && s_tlast) begin
            if (pixD != W16) begin
                pendD[ERR_LINE_LEN] = 1'b1;
            end
            lineD = lineD + 16'd1;
            pixD  = 16'd0;
            if (lineD == H16) begin
                closeEn    = 1'b1;
                closeErr   = pendD;
                closeLines = lineD;
                closeSum   = sumD;
                stateD     = ST_IDLE;
                pendD      = '0;
            end
        end else if (beat && (stateD == ST_ACTIVE) && (pixD == W16)) begin
            pendD[ERR_LINE_LEN] = 1'b1;
        end
    end

    // Report registers are loaded on the closing edge, so they appear one cycle after it.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            readyQ  <= 1'b0;
            stateQ  <= ST_IDLE;
            pixQ    <= '0;
            lineQ   <= '0;
            sumQ    <= '0;
            pendQ   <= '0;
            idleQ   <= '0;
            doneQ   <= 1'b0;
            okQ     <= 1'b0;
            errQ    <= '0;
            linesQ  <= '0;
            sumOutQ <= '0;
            cntQ    <= '0;
        end else begin
            readyQ <= 1'b1;
            stateQ <= stateD;
            pixQ   <= pixD;
            lineQ  <= lineD;
            sumQ   <= sumD;
            pendQ  <= pendD;
            idleQ  <= idleD;
            doneQ  <= closeEn;
            if (closeEn) begin
                errQ    <= closeErr;
                okQ     <= (closeErr == '0);
                linesQ  <= closeLines;
                sumOutQ <= closeSum;
                if (closeErr == '0) begin
                    cntQ <= cntQ + 16'd1;
                end
            end
        end
    end

    assign frame_done  = doneQ;
    assign frame_ok    = okQ;
    assign frame_err   = errQ;
    assign frame_lines = linesQ;
    assign frame_sum   = sumOutQ;
    assign frame_cnt   = cntQ;

endmodule
